// File: rtl/pixel_stream_tx_if.sv
// rtl/pixel_stream_tx_if.sv - pixel stream beat bus with coordinates and frame markers
interface pixel_stream_tx_if #(
   parameter int DATA_W  = 8,
   parameter int COL_BIT = 8,
   parameter int ROW_BIT = 8
);
   logic               px_valid;
   logic               px_ready;
   logic [DATA_W-1:0]  px_data;
   logic [COL_BIT-1:0] px_col;
   logic [ROW_BIT-1:0] px_row;
   logic               px_sof;
   logic               px_eol;
   logic               px_eof;

   modport master (
      output px_valid, px_data, px_col, px_row, px_sof, px_eol, px_eof,
      input  px_ready
   );

   modport slave (
      input  px_valid, px_data, px_col, px_row, px_sof, px_eol, px_eof,
      output px_ready
   );
endinterface

// File: rtl/pixel_stream_tx.sv
// rtl/pixel_stream_tx.sv - raster-order frame reader driving a credit-controlled 2-entry pixel stream
module pixel_stream_tx #(
   parameter int DATA_W  = 8,
   parameter int COL_BIT = 8,
   parameter int ROW_BIT = 8,
   parameter int IMG_W   = 256,
   parameter int IMG_H   = 256
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       mem_rd_en,
   output logic [COL_BIT+ROW_BIT-1:0] mem_addr,
   input  logic [DATA_W-1:0]          mem_rdata,
   pixel_stream_tx_if.master          px
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic [COL_BIT-1:0] col;
      logic [ROW_BIT-1:0] row;
      logic               sof;
      logic               eol;
      logic               eof;
   } meta_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      meta_t             meta;
   } beat_t;

   localparam logic [COL_BIT-1:0] COL_LAST = COL_BIT'(IMG_W - 1);
   localparam logic [ROW_BIT-1:0] ROW_LAST = ROW_BIT'(IMG_H - 1);

   state_t             state_q, state_d;
   logic [COL_BIT-1:0] col_q, col_d;
   logic [ROW_BIT-1:0] row_q, row_d;
   logic               done_q, done_d;
   logic               inflight_q;
   meta_t              meta_q;
   beat_t              buf_q [2];
   logic               wr_ptr_q, rd_ptr_q;
   logic [1:0]         count_q;

   logic               push, pop, last_addr;
   logic [2:0]         occ_next;
   meta_t              meta_issue;
   beat_t              head;

   assign head      = buf_q[rd_ptr_q];
   assign push      = inflight_q;
   assign pop       = (count_q != 2'd0) & px.px_ready;
   // Slots already claimed after this edge: stored words plus the word still in the RAM pipe.
   assign occ_next  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign last_addr = (col_q == COL_LAST) && (row_q == ROW_LAST);

   assign meta_issue = '{col: col_q, row: row_q,
                         sof: (col_q == '0) && (row_q == '0),
                         eol: (col_q == COL_LAST),
                         eof: last_addr};

   assign mem_addr = {row_q, col_q};
   assign busy     = (state_q != IDLE);
   assign done     = done_q;

   assign px.px_valid = (count_q != 2'd0);
   assign px.px_data  = head.data;
   assign px.px_col   = head.meta.col;
   assign px.px_row   = head.meta.row;
   assign px.px_sof   = head.meta.sof;
   assign px.px_eol   = head.meta.eol;
   assign px.px_eof   = head.meta.eof;

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      done_d    = 1'b0;
      mem_rd_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            if (occ_next < 3'd2) begin
               mem_rd_en = 1'b1;
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_BIT'(1);
               end else begin
                  col_d = col_q + COL_BIT'(1);
               end
               if (last_addr) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head.meta.eof) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         col_q      <= '0;
         row_q      <= '0;
         done_q     <= 1'b0;
         inflight_q <= 1'b0;
         meta_q     <= '0;
         buf_q[0]   <= '0;
         buf_q[1]   <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         done_q     <= done_d;
         inflight_q <= mem_rd_en;
         if (mem_rd_en) meta_q <= meta_issue;
         if (push) begin
            buf_q[wr_ptr_q] <= '{data: mem_rdata, meta: meta_q};
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule
